alu_sequencer: RTL and testbench
================================

Name: alu_sequencer

Overview:
Multi-cycle fetch/decode/execute controller for the 8-bit signed ALU datapath. Owns the PC, the instruction register, a 4x8 register file and the latched flag register. Drives the external ALU's sel/A/B and writes back its result. Handles branches, LOADI, STORE and the IN/OUT handshakes, and sits between instruction memory, data memory, I/O and the ALU.

Parameters:
PC_W, 8, width of PC, imem_addr and branch targets (imm field is 8 bits, zero-extended)
RESET_PC, 0, PC value loaded on reset

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  reset, asynchronous assert, active-low
imem_addr  out  PC_W  instruction fetch address
imem_rdata  in  16  instruction word, valid one cycle after imem_addr
alu_sel  out  4  ALU operation select (0 = NOP)
alu_a  out  8  ALU operand A = R[rd]
alu_b  out  8  ALU operand B = R[rs]
alu_y  in  8  ALU result
alu_flag  in  2  ALU flags, [1]=Z, [0]=N
dmem_we  out  1  data memory write strobe, one cycle
dmem_addr  out  8  data memory address
dmem_wdata  out  8  data memory write data
in_data  in  8  input port data
in_valid  in  1  input data available
in_ready  out  1  sequencer accepting input
out_data  out  8  output port data
out_valid  out  1  output data presented
out_ready  in  1  consumer accepts output
flags  out  2  latched flag register {Z,N}
halted  out  1  sequencer stopped

Behaviour:
- Clock and reset: one clock, clk. Reset rst_n is asynchronous and active-low.
- Reset values: state=FETCH, pc=RESET_PC, R0..R3=0, flags=0, ir=0. All outputs are 0 except imem_addr=RESET_PC.
- Instruction format: [15:12] op, [11:10] rd, [9:8] rs, [7:0] imm.
- Opcodes: 0 NOP, 1 ADD, 2 SUB, 3 NAND, 4 SHL, 5 SHR, 6 OUT, 7 IN, 8 MOV, 9 STORE, A LOADI, B BZ, C BN, D JMP, E HALT, F reserved (executes as NOP).
- FETCH: imem_addr=pc. Next state DECODE.
- DECODE: ir<=imem_rdata; pc<=pc+1, wrapping modulo 2^PC_W (0xFF->0x00). Next state EXEC.
- EXEC, ALU ops (1-5, 8):
  - Drives alu_sel=op, alu_a=R[rd], alu_b=R[rs].
  - R[rd]<=alu_y at end of cycle.
  - flags<=alu_flag for ops 1-5 only; MOV leaves flags unchanged.
  - For SHL/SHR the Z slot carries the shifted-out bit, as the ALU defines it.
  - Next state FETCH.
- EXEC, LOADI: R[rd]<=imm; flags unchanged; next state FETCH.
- EXEC, STORE: dmem_we=1, dmem_addr=imm, dmem_wdata=R[rd] for exactly this cycle; next state FETCH.
- EXEC, BZ/BN/JMP:
  - BZ: pc<=imm if flags[1]=1.
  - BN: pc<=imm if flags[0]=1.
  - JMP: pc<=imm unconditionally.
  - Otherwise pc keeps its incremented value.
  - Next state FETCH.
- EXEC, IN/OUT/HALT: next state WAIT_IN / WAIT_OUT / HALT respectively.
- WAIT_IN: in_ready=1. When in_valid=1, R[rd]<=in_data and next state is FETCH; otherwise stay. in_valid outside WAIT_IN is ignored.
- WAIT_OUT: out_valid=1, out_data=R[rd], both stable while waiting. On out_ready=1, next state FETCH.
- HALT: halted=1; terminal until rst_n asserts. No further fetches; imem_addr holds pc.
- Outside EXEC, alu_sel=0, alu_a=0 and alu_b=0.
- Latency per instruction: 3 cycles minimum; IN/OUT take 4 + wait cycles.
- rd==rs is legal: operands are read before writeback.
- A branch target equal to the branch's own address is legal and gives a tight loop.
- Reset mid-operation (e.g. in WAIT_OUT): out_valid, in_ready and dmem_we drop immediately on rst_n low. No partial register write occurs.

Decomposition:
- Package seq_pkg holds:
  - opcode constants OP_NOP..OP_HALT (values 0-E);
  - state enum FETCH/DECODE/EXEC/WAIT_IN/WAIT_OUT/HALT;
  - instruction field bit positions;
  - flag indices FLAG_Z=1, FLAG_N=0.
- Natural sub-module: seq_regfile, 4x8 registers with two combinational read ports, one synchronous write port and asynchronous active-low clear.

Test Plan:
- Reset and arithmetic. Program: LOADI R0,5; LOADI R1,3; SUB R0,R1; HALT -> R0=0x02, flags=00, halted=1 after 12 cycles from reset release, imem_addr sequence 0,1,2,3.
- Flags and BZ. Program: LOADI R0,7; LOADI R1,7; SUB R0,R1; BZ 0x10 -> flags=10, pc=0x10 on next FETCH. With R1=8 instead: flags=01, BZ not taken (pc=0x04), and BN 0x20 is taken.
- IN/OUT handshake:
  - IN R2 with in_valid held low 5 cycles: in_ready stays 1 and no register write occurs.
  - in_valid=1 with in_data=0xA5 -> R2=0xA5.
  - OUT R2 with out_ready low 3 cycles: out_valid=1 and out_data=0xA5 held stable, then handshake completes.
- STORE and MOV. R3=0x3C; STORE R3,0x80 -> single-cycle dmem_we with dmem_addr=0x80, dmem_wdata=0x3C. MOV R0,R3 -> R0=0x3C, flags unchanged.
- Wrap and reset mid-op. JMP 0xFF where 0xFF holds NOP -> next fetch address is 0x00. Assert rst_n low during WAIT_OUT -> out_valid=0 asynchronously; after release, fetch restarts at RESET_PC with all registers 0.

Source files
------------

// File: rtl/seq_pkg.sv
// Shared definitions for the ALU sequencer: opcodes, FSM state codes,
// instruction field positions and flag indices.
package seq_pkg;

  localparam logic [3:0] OP_NOP   = 4'h0;
  localparam logic [3:0] OP_ADD   = 4'h1;
  localparam logic [3:0] OP_SUB   = 4'h2;
  localparam logic [3:0] OP_NAND  = 4'h3;
  localparam logic [3:0] OP_SHL   = 4'h4;
  localparam logic [3:0] OP_SHR   = 4'h5;
  localparam logic [3:0] OP_OUT   = 4'h6;
  localparam logic [3:0] OP_IN    = 4'h7;
  localparam logic [3:0] OP_MOV   = 4'h8;
  localparam logic [3:0] OP_STORE = 4'h9;
  localparam logic [3:0] OP_LOADI = 4'hA;
  localparam logic [3:0] OP_BZ    = 4'hB;
  localparam logic [3:0] OP_BN    = 4'hC;
  localparam logic [3:0] OP_JMP   = 4'hD;
  localparam logic [3:0] OP_HALT  = 4'hE;

  typedef logic [2:0] state_t;
  localparam state_t FETCH    = 3'd0;
  localparam state_t DECODE   = 3'd1;
  localparam state_t EXEC     = 3'd2;
  localparam state_t WAIT_IN  = 3'd3;
  localparam state_t WAIT_OUT = 3'd4;
  localparam state_t HALT     = 3'd5;

  localparam int OP_MSB  = 15;
  localparam int OP_LSB  = 12;
  localparam int RD_MSB  = 11;
  localparam int RD_LSB  = 10;
  localparam int RS_MSB  = 9;
  localparam int RS_LSB  = 8;
  localparam int IMM_MSB = 7;
  localparam int IMM_LSB = 0;

  localparam int FLAG_Z = 1;
  localparam int FLAG_N = 0;

  function automatic logic is_alu_op(input logic [3:0] op);
    case (op)
      OP_ADD, OP_SUB, OP_NAND, OP_SHL, OP_SHR, OP_MOV: is_alu_op = 1'b1;
      default:                                         is_alu_op = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/seq_regfile.sv
// 4x8 register file: two combinational read ports, one synchronous write
// port, asynchronous clear.
module seq_regfile (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       we,
  input  logic [1:0] waddr,
  input  logic [7:0] wdata,
  input  logic [1:0] raddr_a,
  input  logic [1:0] raddr_b,
  output logic [7:0] rdata_a,
  output logic [7:0] rdata_b
);

  logic [7:0] regs_r [4];

  // register storage with async clear
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 4; i++) regs_r[i] <= 8'h00;
    end else if (we) begin
      regs_r[waddr] <= wdata;
    end
  end

  assign rdata_a = regs_r[raddr_a];
  assign rdata_b = regs_r[raddr_b];

endmodule

// File: rtl/alu_sequencer.sv
// Multi-cycle fetch/decode/execute controller for the external 8-bit ALU.
// All outputs are registered; their next values are computed one state ahead.
module alu_sequencer
  import seq_pkg::*;
#(
  parameter int              PC_W     = 8,
  parameter logic [PC_W-1:0] RESET_PC = {PC_W{1'b0}}
) (
  input  logic            clk,
  input  logic            rst_n,
  output logic [PC_W-1:0] imem_addr,
  input  logic [15:0]     imem_rdata,
  output logic [3:0]      alu_sel,
  output logic [7:0]      alu_a,
  output logic [7:0]      alu_b,
  input  logic [7:0]      alu_y,
  input  logic [1:0]      alu_flag,
  output logic            dmem_we,
  output logic [7:0]      dmem_addr,
  output logic [7:0]      dmem_wdata,
  input  logic [7:0]      in_data,
  input  logic            in_valid,
  output logic            in_ready,
  output logic [7:0]      out_data,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [1:0]      flags,
  output logic            halted
);

  state_t          state_r, state_nx_s;
  logic [PC_W-1:0] pc_r, pc_nx_s, target_s;
  logic [15:0]     ir_r, ir_nx_s;
  logic [1:0]      flags_nx_s;
  logic [3:0]      op_s, dec_op_s, alu_sel_nx_s;
  logic [7:0]      alu_a_nx_s, alu_b_nx_s, dmem_addr_nx_s, dmem_wdata_nx_s, out_data_nx_s;
  logic            dmem_we_nx_s, in_ready_nx_s, out_valid_nx_s, halted_nx_s;
  logic            rf_we_s;
  logic [7:0]      rf_wdata_s, rdata_a_s, rdata_b_s;
  logic [1:0]      raddr_a_s, raddr_b_s;

  assign op_s      = ir_r[OP_MSB:OP_LSB];
  assign dec_op_s  = imem_rdata[OP_MSB:OP_LSB];
  assign target_s  = PC_W'(ir_r[IMM_MSB:IMM_LSB]);
  assign imem_addr = pc_r;
  // In DECODE the operands are read from the incoming word so they are ready in EXEC
  assign raddr_a_s = (state_r == DECODE) ? imem_rdata[RD_MSB:RD_LSB] : ir_r[RD_MSB:RD_LSB];
  assign raddr_b_s = (state_r == DECODE) ? imem_rdata[RS_MSB:RS_LSB] : ir_r[RS_MSB:RS_LSB];

  seq_regfile u_regfile (
    .clk     (clk),
    .rst_n   (rst_n),
    .we      (rf_we_s),
    .waddr   (ir_r[RD_MSB:RD_LSB]),
    .wdata   (rf_wdata_s),
    .raddr_a (raddr_a_s),
    .raddr_b (raddr_b_s),
    .rdata_a (rdata_a_s),
    .rdata_b (rdata_b_s)
  );

  // next-state, register-write and next-output computation
  always_comb begin
    state_nx_s      = state_r;
    pc_nx_s         = pc_r;
    ir_nx_s         = ir_r;
    flags_nx_s      = flags;
    rf_we_s         = 1'b0;
    rf_wdata_s      = 8'h00;
    alu_sel_nx_s    = OP_NOP;
    alu_a_nx_s      = 8'h00;
    alu_b_nx_s      = 8'h00;
    dmem_we_nx_s    = 1'b0;
    dmem_addr_nx_s  = 8'h00;
    dmem_wdata_nx_s = 8'h00;
    in_ready_nx_s   = 1'b0;
    out_valid_nx_s  = 1'b0;
    out_data_nx_s   = 8'h00;
    halted_nx_s     = 1'b0;
    case (state_r)
      FETCH: state_nx_s = DECODE;
      DECODE: begin
        ir_nx_s    = imem_rdata;
        pc_nx_s    = pc_r + PC_W'(1'b1);
        state_nx_s = EXEC;
        if (is_alu_op(dec_op_s)) begin
          alu_sel_nx_s = dec_op_s;
          alu_a_nx_s   = rdata_a_s;
          alu_b_nx_s   = rdata_b_s;
        end else begin
          alu_sel_nx_s = OP_NOP;
        end
        if (dec_op_s == OP_STORE) begin
          dmem_we_nx_s    = 1'b1;
          dmem_addr_nx_s  = imem_rdata[IMM_MSB:IMM_LSB];
          dmem_wdata_nx_s = rdata_a_s;
        end else begin
          dmem_we_nx_s = 1'b0;
        end
      end
      EXEC: begin
        state_nx_s = FETCH;
        case (op_s)
          OP_ADD, OP_SUB, OP_NAND, OP_SHL, OP_SHR, OP_MOV: begin
            rf_we_s    = 1'b1;
            rf_wdata_s = alu_y;
            if (op_s != OP_MOV) flags_nx_s = alu_flag;
            else                flags_nx_s = flags;
          end
          OP_LOADI: begin
            rf_we_s    = 1'b1;
            rf_wdata_s = ir_r[IMM_MSB:IMM_LSB];
          end
          OP_BZ: if (flags[FLAG_Z]) pc_nx_s = target_s; else pc_nx_s = pc_r;
          OP_BN: if (flags[FLAG_N]) pc_nx_s = target_s; else pc_nx_s = pc_r;
          OP_JMP: pc_nx_s = target_s;
          OP_IN: begin
            state_nx_s    = WAIT_IN;
            in_ready_nx_s = 1'b1;
          end
          OP_OUT: begin
            state_nx_s     = WAIT_OUT;
            out_valid_nx_s = 1'b1;
            out_data_nx_s  = rdata_a_s;
          end
          OP_HALT: begin
            state_nx_s  = HALT;
            halted_nx_s = 1'b1;
          end
          default: state_nx_s = FETCH;
        endcase
      end
      WAIT_IN: begin
        if (in_valid) begin
          rf_we_s    = 1'b1;
          rf_wdata_s = in_data;
          state_nx_s = FETCH;
        end else begin
          in_ready_nx_s = 1'b1;
        end
      end
      WAIT_OUT: begin
        if (out_ready) begin
          state_nx_s = FETCH;
        end else begin
          out_valid_nx_s = 1'b1;
          out_data_nx_s  = out_data;
        end
      end
      HALT:    halted_nx_s = 1'b1;
      default: state_nx_s = FETCH;
    endcase
  end

  // state, PC, IR, flags and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r    <= FETCH;
      pc_r       <= RESET_PC;
      ir_r       <= 16'h0000;
      flags      <= 2'b00;
      alu_sel    <= 4'h0;
      alu_a      <= 8'h00;
      alu_b      <= 8'h00;
      dmem_we    <= 1'b0;
      dmem_addr  <= 8'h00;
      dmem_wdata <= 8'h00;
      in_ready   <= 1'b0;
      out_valid  <= 1'b0;
      out_data   <= 8'h00;
      halted     <= 1'b0;
    end else begin
      state_r    <= state_nx_s;
      pc_r       <= pc_nx_s;
      ir_r       <= ir_nx_s;
      flags      <= flags_nx_s;
      alu_sel    <= alu_sel_nx_s;
      alu_a      <= alu_a_nx_s;
      alu_b      <= alu_b_nx_s;
      dmem_we    <= dmem_we_nx_s;
      dmem_addr  <= dmem_addr_nx_s;
      dmem_wdata <= dmem_wdata_nx_s;
      in_ready   <= in_ready_nx_s;
      out_valid  <= out_valid_nx_s;
      out_data   <= out_data_nx_s;
      halted     <= halted_nx_s;
    end
  end

endmodule

// File: tb/tb_alu_sequencer.sv
// Self-checking bench for alu_sequencer: directed scenarios plus random
// programs compared against an instruction-level reference interpreter.
module tb_alu_sequencer;
  import seq_pkg::*;

  logic        clk, rst_n;
  logic [7:0]  imem_addr;
  logic [15:0] imem_rdata;
  logic [3:0]  alu_sel;
  logic [7:0]  alu_a, alu_b, alu_y;
  logic [1:0]  alu_flag;
  logic        dmem_we;
  logic [7:0]  dmem_addr, dmem_wdata;
  logic [7:0]  in_data;
  logic        in_valid, in_ready;
  logic [7:0]  out_data;
  logic        out_valid, out_ready;
  logic [1:0]  flags;
  logic        halted;

  int checks = 0;
  int errors = 0;

  logic [15:0] imem [256];
  logic [9:0]  alu_res;
  logic [7:0]  in_vals [$];
  logic [7:0]  exp_out [$];
  logic [7:0]  obs_out [$];
  logic [15:0] exp_st [$];
  logic [15:0] obs_st [$];
  logic [1:0]  m_flags;
  int          in_idx;

  alu_sequencer #(.PC_W(8), .RESET_PC(8'h00)) dut (
    .clk(clk), .rst_n(rst_n), .imem_addr(imem_addr), .imem_rdata(imem_rdata),
    .alu_sel(alu_sel), .alu_a(alu_a), .alu_b(alu_b), .alu_y(alu_y), .alu_flag(alu_flag),
    .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .flags(flags), .halted(halted)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) imem_rdata <= imem[imem_addr];

  // ALU behaviour: returns {Z, N, y}; shifts report the shifted-out bit in Z
  function automatic logic [9:0] alu_fn(input logic [3:0] sel, input logic [7:0] a, input logic [7:0] b);
    logic [7:0] y;
    logic       z;
    case (sel)
      4'h1:    y = a + b;
      4'h2:    y = a - b;
      4'h3:    y = ~(a & b);
      4'h4:    y = {a[6:0], 1'b0};
      4'h5:    y = {a[7], a[7:1]};
      4'h8:    y = b;
      default: y = 8'h00;
    endcase
    z = (y == 8'h00);
    if (sel == 4'h4) z = a[7];
    if (sel == 4'h5) z = a[0];
    return {z, y[7], y};
  endfunction

  always_comb alu_res = alu_fn(alu_sel, alu_a, alu_b);
  assign alu_y    = alu_res[7:0];
  assign alu_flag = alu_res[9:8];

  function automatic logic [15:0] ins(input logic [3:0] op, input logic [1:0] rd, input logic [1:0] rs, input logic [7:0] imm);
    return {op, rd, rs, imm};
  endfunction

  task automatic clear_imem();
    for (int i = 0; i < 256; i++) imem[i] = 16'h0000;
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; in_data = 8'h00;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Instruction-level interpreter: architectural state only, one instruction per iteration
  task automatic model_run();
    logic [7:0]  r [4];
    logic [7:0]  pc;
    logic [15:0] w;
    logic [3:0]  op;
    logic [9:0]  res;
    int          k, steps;
    bit          done;
    for (int i = 0; i < 4; i++) r[i] = 8'h00;
    pc = 8'h00; m_flags = 2'b00; k = 0; steps = 0; done = 1'b0;
    exp_out.delete(); exp_st.delete();
    while (!done && steps < 2000) begin
      w = imem[pc]; pc = pc + 8'd1; op = w[15:12]; steps++;
      case (op)
        OP_ADD, OP_SUB, OP_NAND, OP_SHL, OP_SHR, OP_MOV: begin
          res = alu_fn(op, r[w[11:10]], r[w[9:8]]);
          r[w[11:10]] = res[7:0];
          if (op != OP_MOV) m_flags = res[9:8];
        end
        OP_LOADI: r[w[11:10]] = w[7:0];
        OP_STORE: exp_st.push_back({w[7:0], r[w[11:10]]});
        OP_BZ:    if (m_flags[1]) pc = w[7:0];
        OP_BN:    if (m_flags[0]) pc = w[7:0];
        OP_JMP:   pc = w[7:0];
        OP_IN:    begin r[w[11:10]] = in_vals[k]; k++; end
        OP_OUT:   exp_out.push_back(r[w[11:10]]);
        OP_HALT:  done = 1'b1;
        default:  ;
      endcase
    end
  endtask

  // Run the DUT until halted, recording stores and output transfers
  task automatic run_dut(input bit rand_io, input int max_cyc);
    int n;
    n = 0; in_idx = 0;
    obs_out.delete(); obs_st.delete();
    while (!halted && n < max_cyc) begin
      @(negedge clk); n++;
      if (dmem_we) obs_st.push_back({dmem_addr, dmem_wdata});
      in_valid  = rand_io ? 1'($urandom_range(0, 1)) : 1'b1;
      out_ready = rand_io ? 1'($urandom_range(0, 1)) : 1'b1;
      in_data   = (in_idx < in_vals.size()) ? in_vals[in_idx] : 8'h00;
      if (in_ready && in_valid) in_idx++;
      if (out_valid && out_ready) obs_out.push_back(out_data);
    end
    in_valid = 1'b0; out_ready = 1'b0;
    checks++;
    if (halted !== 1'b1) begin errors++; $display("FAIL run_timeout: halted=%b after %0d cycles, required 1", halted, n); end
  endtask

  task automatic test_reset();
    clear_imem();
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; in_data = 8'h00;
    step(2);
    checks++;
    if ({imem_addr, alu_sel, alu_a, alu_b, dmem_we, dmem_addr, dmem_wdata, in_ready, out_data, out_valid, flags, halted} !== 56'h0) begin
      errors++; $display("FAIL reset_outputs: addr=%h sel=%h a=%h b=%h we=%b rdy=%b ov=%b fl=%b h=%b, required all 0",
                         imem_addr, alu_sel, alu_a, alu_b, dmem_we, in_ready, out_valid, flags, halted);
    end
  endtask

  task automatic test_arith();
    clear_imem();
    imem[0] = ins(OP_LOADI, 2'd0, 2'd0, 8'h05);
    imem[1] = ins(OP_LOADI, 2'd1, 2'd0, 8'h03);
    imem[2] = ins(OP_SUB, 2'd0, 2'd1, 8'h00);
    imem[3] = ins(OP_HALT, 2'd0, 2'd0, 8'h00);
    do_reset();
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (imem_addr !== 8'(i)) begin errors++; $display("FAIL fetch_addr%0d: got %h, required %h", i, imem_addr, 8'(i)); end
      if (i == 2) begin
        step(2);
        checks++;
        if ({alu_sel, alu_a, alu_b} !== {OP_SUB, 8'h05, 8'h03}) begin
          errors++; $display("FAIL sub_operands: sel=%h a=%h b=%h, required 2 05 03", alu_sel, alu_a, alu_b);
        end
        step(1);
      end else if (i < 3) step(3);
      else step(0);
    end
    step(2);
    checks++;
    if (halted !== 1'b0) begin errors++; $display("FAIL halt_early: halted=%b at cycle 11, required 0", halted); end
    step(1);
    checks++;
    if ({halted, flags} !== 3'b100) begin errors++; $display("FAIL halt_cycle12: halted=%b flags=%b, required 1 00", halted, flags); end
    step(5);
    checks++;
    if ({halted, imem_addr} !== {1'b1, 8'h04}) begin errors++; $display("FAIL halt_hold: halted=%b addr=%h, required 1 04", halted, imem_addr); end
    imem[3] = ins(OP_OUT, 2'd0, 2'd0, 8'h00);
    imem[4] = ins(OP_HALT, 2'd0, 2'd0, 8'h00);
    do_reset();
    run_dut(1'b0, 200);
    checks++;
    if (obs_out.size() != 1 || obs_out[0] !== 8'h02) begin
      errors++; $display("FAIL sub_result: %0d outputs, first=%h, required 1 output 02", obs_out.size(), (obs_out.size() > 0) ? obs_out[0] : 8'hxx);
    end
  endtask

  task automatic test_branch();
    clear_imem();
    imem[0]    = ins(OP_LOADI, 2'd0, 2'd0, 8'h07);
    imem[1]    = ins(OP_LOADI, 2'd1, 2'd0, 8'h07);
    imem[2]    = ins(OP_SUB, 2'd0, 2'd1, 8'h00);
    imem[3]    = ins(OP_BZ, 2'd0, 2'd0, 8'h10);
    imem[4]    = ins(OP_BN, 2'd0, 2'd0, 8'h20);
    imem[8'h10] = ins(OP_HALT, 2'd0, 2'd0, 8'h00);
    imem[8'h20] = ins(OP_HALT, 2'd0, 2'd0, 8'h00);
    do_reset();
    step(12);
    checks++;
    if ({flags, imem_addr} !== {2'b10, 8'h10}) begin errors++; $display("FAIL bz_taken: flags=%b addr=%h, required 10 10", flags, imem_addr); end
    imem[1] = ins(OP_LOADI, 2'd1, 2'd0, 8'h08);
    do_reset();
    step(9);
    checks++;
    if (flags !== 2'b01) begin errors++; $display("FAIL neg_flags: flags=%b, required 01", flags); end
    step(3);
    checks++;
    if (imem_addr !== 8'h04) begin errors++; $display("FAIL bz_not_taken: addr=%h, required 04", imem_addr); end
    step(3);
    checks++;
    if (imem_addr !== 8'h20) begin errors++; $display("FAIL bn_taken: addr=%h, required 20", imem_addr); end
  endtask

  task automatic test_in_out();
    clear_imem();
    imem[0] = ins(OP_IN, 2'd2, 2'd0, 8'h00);
    imem[1] = ins(OP_OUT, 2'd2, 2'd0, 8'h00);
    imem[2] = ins(OP_HALT, 2'd0, 2'd0, 8'h00);
    do_reset();
    in_data = 8'h5A;
    step(3);
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (in_ready !== 1'b1) begin errors++; $display("FAIL in_wait%0d: in_ready=%b, required 1", i, in_ready); end
      step(1);
    end
    in_valid = 1'b1; in_data = 8'hA5;
    step(1);
    in_valid = 1'b0; in_data = 8'h00;
    checks++;
    if (in_ready !== 1'b0) begin errors++; $display("FAIL in_done: in_ready=%b, required 0", in_ready); end
    step(3);
    for (int i = 0; i < 3; i++) begin
      checks++;
      if ({out_valid, out_data} !== {1'b1, 8'hA5}) begin
        errors++; $display("FAIL out_wait%0d: valid=%b data=%h, required 1 a5", i, out_valid, out_data);
      end
      step(1);
    end
    out_ready = 1'b1;
    step(1);
    out_ready = 1'b0;
    checks++;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL out_done: out_valid=%b, required 0", out_valid); end
  endtask

  task automatic test_store_mov();
    clear_imem();
    imem[0] = ins(OP_LOADI, 2'd3, 2'd0, 8'h3C);
    imem[1] = ins(OP_SUB, 2'd1, 2'd1, 8'h00);
    imem[2] = ins(OP_STORE, 2'd3, 2'd0, 8'h80);
    imem[3] = ins(OP_MOV, 2'd0, 2'd3, 8'h00);
    imem[4] = ins(OP_OUT, 2'd0, 2'd0, 8'h00);
    imem[5] = ins(OP_HALT, 2'd0, 2'd0, 8'h00);
    do_reset();
    run_dut(1'b0, 200);
    checks++;
    if (obs_st.size() != 1 || obs_st[0] !== 16'h803C) begin
      errors++; $display("FAIL store: %0d strobes, first=%h, required 1 strobe 803c", obs_st.size(), (obs_st.size() > 0) ? obs_st[0] : 16'hxxxx);
    end
    checks++;
    if (obs_out.size() != 1 || obs_out[0] !== 8'h3C || flags !== 2'b10) begin
      errors++; $display("FAIL mov: %0d outputs, flags=%b, required one 3c output and flags 10", obs_out.size(), flags);
    end
  endtask

  task automatic test_wrap_reset();
    clear_imem();
    imem[0]     = ins(OP_JMP, 2'd0, 2'd0, 8'hFF);
    imem[8'hFF] = ins(OP_NOP, 2'd0, 2'd0, 8'h00);
    do_reset();
    step(3);
    checks++;
    if (imem_addr !== 8'hFF) begin errors++; $display("FAIL jmp_ff: addr=%h, required ff", imem_addr); end
    step(3);
    checks++;
    if (imem_addr !== 8'h00) begin errors++; $display("FAIL pc_wrap: addr=%h, required 00", imem_addr); end
    clear_imem();
    imem[0] = ins(OP_LOADI, 2'd1, 2'd0, 8'h77);
    imem[1] = ins(OP_OUT, 2'd1, 2'd0, 8'h00);
    do_reset();
    step(6);
    checks++;
    if ({out_valid, out_data} !== {1'b1, 8'h77}) begin errors++; $display("FAIL pre_reset_out: valid=%b data=%h, required 1 77", out_valid, out_data); end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({out_valid, in_ready, dmem_we, imem_addr} !== 11'h0) begin
      errors++; $display("FAIL async_reset: valid=%b rdy=%b we=%b addr=%h, required all 0", out_valid, in_ready, dmem_we, imem_addr);
    end
    imem[0] = ins(OP_OUT, 2'd1, 2'd0, 8'h00);
    imem[1] = ins(OP_HALT, 2'd0, 2'd0, 8'h00);
    @(negedge clk);
    rst_n = 1'b1;
    run_dut(1'b0, 100);
    checks++;
    if (obs_out.size() != 1 || obs_out[0] !== 8'h00) begin
      errors++; $display("FAIL regs_cleared: %0d outputs, first=%h, required one 00", obs_out.size(), (obs_out.size() > 0) ? obs_out[0] : 8'hxx);
    end
  endtask

  task automatic test_random();
    int          n_ins;
    logic [3:0]  op;
    for (int t = 0; t < 6; t++) begin
      clear_imem();
      n_ins = 24;
      for (int i = 0; i < n_ins; i++) begin
        op = 4'($urandom_range(0, 15));
        if (op == OP_HALT) op = OP_NOP;
        imem[i] = ins(op, 2'($urandom), 2'($urandom), 8'($urandom));
        if (op == OP_BZ || op == OP_BN || op == OP_JMP) imem[i][7:0] = 8'($urandom_range(i + 1, n_ins));
      end
      for (int i = 0; i < 4; i++) imem[n_ins + i] = ins(OP_OUT, 2'(i), 2'd0, 8'h00);
      imem[n_ins + 4] = ins(OP_HALT, 2'd0, 2'd0, 8'h00);
      in_vals.delete();
      for (int i = 0; i < 32; i++) in_vals.push_back(8'($urandom));
      model_run();
      do_reset();
      run_dut(1'b1, 3000);
      checks++;
      if (obs_out.size() != exp_out.size()) begin
        errors++; $display("FAIL rand%0d_out_count: got %0d, required %0d", t, obs_out.size(), exp_out.size());
      end else begin
        for (int i = 0; i < exp_out.size(); i++) begin
          checks++;
          if (obs_out[i] !== exp_out[i]) begin errors++; $display("FAIL rand%0d_out%0d: got %h, required %h", t, i, obs_out[i], exp_out[i]); end
        end
      end
      checks++;
      if (obs_st.size() != exp_st.size()) begin
        errors++; $display("FAIL rand%0d_store_count: got %0d, required %0d", t, obs_st.size(), exp_st.size());
      end else begin
        for (int i = 0; i < exp_st.size(); i++) begin
          checks++;
          if (obs_st[i] !== exp_st[i]) begin errors++; $display("FAIL rand%0d_store%0d: got %h, required %h", t, i, obs_st[i], exp_st[i]); end
        end
      end
      checks++;
      if (flags !== m_flags) begin errors++; $display("FAIL rand%0d_flags: got %b, required %b", t, flags, m_flags); end
    end
  endtask

  initial begin
    test_reset();
    test_arith();
    test_branch();
    test_in_out();
    test_store_mov();
    test_wrap_reset();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
